ram_bus_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 16x4 synchronous RAM between two independent requesters, e.g. the switch-driven manual port and an automatic scan/fill engine. It serialises requests with round-robin fairness, sequences each access through a fixed three-state FSM, and returns one-cycle acknowledges with registered read data. It sits between the requesters and the RAM instance, in the divided-clock domain.

---
 rtl/ram_bus_pkg.sv | 11 +
 rtl/rr_arb2.sv | 11 +
 rtl/ram_bus_arbiter.sv | 95 +++++++++
 tb/tb_ram_bus_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_bus_pkg.sv
// Shared types and defaults for the two-requester RAM bus arbiter.
package ram_bus_pkg;
  localparam int AW_DEF = 4;
  localparam int DW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker; the pointer register lives in the caller.
module rr_arb2 (
  input  logic [1:0] elig,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  // On a tie the requester not served last wins; otherwise the lone one wins.
  assign gnt_valid = |elig;
  assign gnt_idx   = (&elig) ? ~last : elig[1];
endmodule

// File: rtl/ram_bus_arbiter.sv
// Serialises two requesters onto one synchronous single-port RAM with
// round-robin fairness, a fixed IDLE/ISSUE/CAPTURE sequence and registered acks.
module ram_bus_arbiter
  import ram_bus_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          CLK100MHZ,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          owner,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);
  arb_state_t    state, next_state;
  logic          last;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic [1:0]    elig;
  logic          gnt_valid, gnt_idx, grant;

  // A requester in its ack cycle has not yet had a chance to drop req.
  assign elig  = req & ~ack;
  assign grant = (state == IDLE) && gnt_valid;

  rr_arb2 u_rr (
    .elig      (elig),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (gnt_valid) next_state = ISSUE;
      ISSUE:   next_state = CAPTURE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      last   <= 1'b1;
      owner  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      ack    <= '0;
      rdata  <= '0;
    end else begin
      ack <= '0;
      if (grant) begin
        last   <= gnt_idx;
        owner  <= gnt_idx;
        we_q   <= we[gnt_idx];
        addr_q <= gnt_idx ? addr1  : addr0;
        din_q  <= gnt_idx ? wdata1 : wdata0;
      end
      if (state == CAPTURE) begin
        ack[owner] <= 1'b1;
        if (!we_q) rdata <= ram_dout;
      end
    end
  end

  // Address/data always come from the latches so the RAM sees no glitches;
  // gating the strobe by rst_n blocks a write when reset lands in ISSUE.
  assign busy     = (state != IDLE);
  assign ram_we   = (state == ISSUE) && we_q && rst_n;
  assign ram_addr = addr_q;
  assign ram_din  = din_q;
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Scoreboard bench for ram_bus_arbiter with a behavioural synchronous 16x4 RAM.
module tb_ram_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, we, ack;
  logic [3:0] addr0, addr1, wdata0, wdata1, rdata;
  logic       busy, owner, ram_we;
  logic [3:0] ram_addr, ram_din, ram_dout;

  always #5 clk = ~clk;

  ram_bus_arbiter #(.AW(4), .DW(4)) dut (
    .CLK100MHZ(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata(rdata), .busy(busy), .owner(owner),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Behavioural RAM: read-first, data valid on the edge after the address.
  logic [3:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    mem[1] = 4'h6;
    mem[7] = 4'h2;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    int         idx;
    bit         rd;
    logic [3:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   ack_times[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   we_cnt   = 0;
  int   we_cyc   = 0;
  logic [3:0] we_addr, we_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM strobe monitor: records every write that actually reaches the RAM.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      we_cnt  = we_cnt + 1;
      we_cyc  = cyc;
      we_addr = ram_addr;
      we_din  = ram_din;
    end
  end

  // Scoreboard monitor: every ack pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ack !== 2'b00 && ack !== 2'bxx) begin
      ack_times.push_back(cyc);
      if (sb.size() == 0) begin
        check("ack_unexpected", {30'd0, ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_onehot", {30'd0, ack}, (e.idx == 1) ? 32'd2 : 32'd1);
        if (e.rd) check("rdata", {28'd0, rdata}, {28'd0, e.rdata});
      end
    end
  end

  function automatic exp_t mk(input int idx, input bit rd, input logic [3:0] d);
    exp_t e;
    e.idx = idx; e.rd = rd; e.rdata = d;
    return e;
  endfunction

  task automatic wait_ack(input int idx);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack[idx] === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) check("ack_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic access(input int idx, input bit w, input logic [3:0] a,
                        input logic [3:0] d, input logic [3:0] rd_exp);
    @(posedge clk); #1;
    we[idx] = w;
    if (idx == 0) begin addr0 = a; wdata0 = d; end
    else          begin addr1 = a; wdata1 = d; end
    sb.push_back(mk(idx, !w, rd_exp));
    req[idx] = 1'b1;
    wait_ack(idx);
    @(posedge clk); #1;
    req[idx] = 1'b0;
  endtask

  initial begin
    int base, seen, we_before;
    rst_n = 1'b0; req = 2'b11; we = 2'b11;
    addr0 = 4'h0; addr1 = 4'h1; wdata0 = 4'h0; wdata1 = 4'h0;

    // Reset held two edges with both requesting writes.
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    end
    check("rst_ack",   {30'd0, ack},   32'd0);
    check("rst_rdata", {28'd0, rdata}, 32'd0);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_owner", {31'd0, owner}, 32'd0);
    check("rst_addr",  {28'd0, ram_addr}, 32'd0);
    check("rst_din",   {28'd0, ram_din},  32'd0);
    check("rst_no_write", we_cnt, 32'd0);

    // Release with both reading continuously: 0 wins the first tie, then alternate.
    we = 2'b00;
    sb.push_back(mk(0, 1, 4'h0));
    sb.push_back(mk(1, 1, 4'h6));
    sb.push_back(mk(0, 1, 4'h0));
    sb.push_back(mk(1, 1, 4'h6));
    base = ack_times.size();
    rst_n = 1'b1;
    @(negedge clk);
    check("first_owner", {31'd0, owner}, 32'd0);
    check("first_busy",  {31'd0, busy},  32'd1);
    seen = 0;
    for (int i = 0; i < 40 && seen < 4; i++) begin
      @(negedge clk);
      if (ack !== 2'b00) seen++;
      if (seen == 4) req = 2'b00;
    end
    check("contention_acks", seen, 32'd4);
    req = 2'b00;
    for (int i = 0; i < 3; i++)
      if (ack_times.size() > base + i + 1)
        check("contention_gap", ack_times[base+i+1] - ack_times[base+i], 32'd3);

    // Single write then read back.
    we_before = we_cnt;
    access(0, 1'b1, 4'h5, 4'hA, 4'h0);
    check("wr_strobe_count", we_cnt - we_before, 32'd1);
    check("wr_addr", {28'd0, we_addr}, 32'h5);
    check("wr_din",  {28'd0, we_din},  32'hA);
    check("wr_ack_latency", ack_times[$] - we_cyc, 32'd2);
    access(0, 1'b0, 4'h5, 4'h0, 4'hA);

    // Sticky req: held through the ack cycle and one more is a second request.
    @(posedge clk); #1;
    we[1] = 1'b0; addr1 = 4'h5;
    sb.push_back(mk(1, 1, 4'hA));
    sb.push_back(mk(1, 1, 4'hA));
    base = ack_times.size();
    req[1] = 1'b1;
    wait_ack(1);
    @(posedge clk); #1;
    @(negedge clk);
    check("sticky_gap_idle", {31'd0, busy}, 32'd0);
    wait_ack(1);
    @(posedge clk); #1;
    req[1] = 1'b0;
    // Ack cycle is ineligible, grant one cycle later: 3-cycle access + 1.
    if (ack_times.size() >= base + 2)
      check("sticky_ack_spacing", ack_times[base+1] - ack_times[base], 32'd4);
    else
      check("sticky_ack_count", ack_times.size() - base, 32'd2);

    // Reset lands in the ISSUE cycle of a write: no RAM write, no ack.
    we_before = we_cnt;
    @(posedge clk); #1;
    we[0] = 1'b1; addr0 = 4'h3; wdata0 = 4'hF;
    req[0] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; req[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_write", we_cnt - we_before, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rdata", {28'd0, rdata}, 32'd0);

    // Mixed contention after reset: requester 0 reads 7 before 1 writes 9 there.
    @(posedge clk); #1;
    we = 2'b10; addr0 = 4'h7; addr1 = 4'h7; wdata1 = 4'h9;
    sb.push_back(mk(0, 1, 4'h2));
    sb.push_back(mk(1, 0, 4'h0));
    req = 2'b11;
    wait_ack(0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    wait_ack(1);
    @(posedge clk); #1;
    req[1] = 1'b0;
    access(0, 1'b0, 4'h7, 4'h0, 4'h9);
    access(0, 1'b0, 4'h3, 4'h0, 4'h0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
